// File: rtl/agc_pkg.sv
// Shared types and default constants for the receive AGC controller.
package agc_pkg;

  localparam int unsigned GAIN_WIDTH_DEF    = 7;
  localparam int unsigned COARSE_STEP_DEF   = 6;
  localparam int unsigned SETTLE_CYCLES_DEF = 4096;
  localparam int unsigned LEVEL_WIDTH       = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    SETTLE   = 2'd2,
    DECIDE   = 2'd3
  } agc_state_e;

endpackage

// File: rtl/agc_gain_step.sv
// Saturating add of a signed step to an unsigned gain code, clamped to [0, 2^GAIN_WIDTH-1].
module agc_gain_step
  import agc_pkg::*;
#(
  parameter int unsigned GAIN_WIDTH = GAIN_WIDTH_DEF
) (
  input  logic        [GAIN_WIDTH-1:0] gain,
  input  logic signed [GAIN_WIDTH:0]   step,
  output logic        [GAIN_WIDTH-1:0] new_gain_c
);

  localparam int unsigned SUM_W = GAIN_WIDTH + 2;

  // One extra bit of headroom so GAIN_MAX+1 cannot wrap negative.
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] gain_max;

  assign gain_max = $signed({2'b00, {GAIN_WIDTH{1'b1}}});
  assign sum      = $signed({2'b00, gain}) + $signed({step[GAIN_WIDTH], step});

  always_comb begin
    new_gain_c = gain;
    if (sum < 0) begin
      new_gain_c = '0;
    end else if (sum > gain_max) begin
      new_gain_c = '1;
    end else begin
      new_gain_c = sum[GAIN_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/rx_agc_ctrl.sv
// Closed-loop receive AGC: settles after each gain load, then steps gain toward target,
// with overload forcing a coarse reduction. Gain is handed to the loader via req/ack.
module rx_agc_ctrl
  import agc_pkg::*;
#(
  parameter int unsigned GAIN_WIDTH    = GAIN_WIDTH_DEF,
  parameter int unsigned COARSE_STEP   = COARSE_STEP_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LEVEL_WIDTH-1:0] rssi,
  input  logic [LEVEL_WIDTH-1:0] over_count,
  input  logic [LEVEL_WIDTH-1:0] target,
  input  logic [LEVEL_WIDTH-1:0] hysteresis,
  input  logic [LEVEL_WIDTH-1:0] over_thresh,
  input  logic [GAIN_WIDTH-1:0]  manual_gain,
  output logic [GAIN_WIDTH-1:0]  gain,
  output logic                   gain_req,
  input  logic                   gain_ack,
  output logic                   locked
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic signed [GAIN_WIDTH:0] STEP_COARSE = -$signed((GAIN_WIDTH+1)'(COARSE_STEP));
  localparam logic signed [GAIN_WIDTH:0] STEP_DOWN   = '1;
  localparam logic signed [GAIN_WIDTH:0] STEP_UP     = (GAIN_WIDTH+1)'(1);

  agc_state_e                  state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic [GAIN_WIDTH-1:0]       gain_nxt;
  logic                        req_nxt;
  logic                        locked_nxt;
  logic signed [GAIN_WIDTH:0]  step;
  logic                        adjust;
  logic [GAIN_WIDTH-1:0]       new_gain_c;
  logic [LEVEL_WIDTH:0]        upper_c;
  logic [LEVEL_WIDTH:0]        rssi_hi_c;

  // 17-bit sums so large target/hysteresis values never wrap.
  assign upper_c   = {1'b0, target} + {1'b0, hysteresis};
  assign rssi_hi_c = {1'b0, rssi} + {1'b0, hysteresis};

  // Decision priority: overload, too hot, too cold, else deadband.
  always_comb begin
    step   = '0;
    adjust = 1'b1;
    if (over_count > over_thresh) begin
      step = STEP_COARSE;
    end else if ({1'b0, rssi} > upper_c) begin
      step = STEP_DOWN;
    end else if (rssi_hi_c < {1'b0, target}) begin
      step = STEP_UP;
    end else begin
      adjust = 1'b0;
    end
  end

  agc_gain_step #(.GAIN_WIDTH(GAIN_WIDTH)) u_gain_step (
    .gain       (gain),
    .step       (step),
    .new_gain_c (new_gain_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      gain     <= '0;
      gain_req <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gain     <= gain_nxt;
      gain_req <= req_nxt;
      locked   <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    gain_nxt   = gain;
    req_nxt    = gain_req;
    locked_nxt = locked;
    if (!enable) begin
      // Disabling abandons any outstanding request; gain holds.
      state_nxt  = IDLE;
      req_nxt    = 1'b0;
      locked_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          gain_nxt  = manual_gain;
          req_nxt   = 1'b1;
          state_nxt = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (gain_ack) begin
            req_nxt   = 1'b0;
            cnt_nxt   = CNT_LOAD;
            state_nxt = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state_nxt = DECIDE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        DECIDE: begin
          if (adjust && (new_gain_c != gain)) begin
            locked_nxt = 1'b0;
            gain_nxt   = new_gain_c;
            req_nxt    = 1'b1;
            state_nxt  = WAIT_ACK;
          end else begin
            locked_nxt = !adjust;
            cnt_nxt    = CNT_LOAD;
            state_nxt  = SETTLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
